// File: rtl/reg_lock_scoreboard.sv
// Register lock scoreboard: tracks in-flight destinations and serialises blocking instructions.
// Latency: pl_ready_o is same-cycle combinational; lock and state updates appear one cycle later.
// Backpressure: pl_ready_o drops on a source hazard, for blocking drain or blocked phases, and on flush.

package rv64g_pkg;
  localparam int NUM_REGS = 64;
endpackage

module reg_lock_scoreboard #(
  parameter int NR = rv64g_pkg::NUM_REGS,
  parameter int NW = 2,
  parameter int CW = 16,
  localparam int LNR = $clog2(NR)
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic              flush_i,
  input  logic              pl_valid_i,
  output logic              pl_ready_o,
  input  logic              blocking_i,
  input  logic [LNR-1:0]    rd_i,
  input  logic [NR-1:0]     reg_req_i,
  input  logic [NW-1:0]     wb_valid_i,
  input  logic [NW*LNR-1:0] wb_rd_i,
  input  logic              blk_done_i,
  output logic [NR-1:0]     locks_o,
  output logic [1:0]        state_o,
  output logic [CW-1:0]     stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    BLOCKED = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [NR-1:0]   locks_q, locks_d;
  logic [NR-1:0]   wb_clr;
  logic [NR-1:0]   rd_oh;
  logic [NR-1:0]   eff;
  logic            eff_zero;
  logic            hazard;
  logic [CW-1:0]   stall_q;

  // Collect writeback clears; out-of-range indices are dropped.
  always_comb begin
    wb_clr = '0;
    for (int k = 0; k < NW; k++) begin
      if (wb_valid_i[k] && (int'(wb_rd_i[k*LNR +: LNR]) < NR)) begin
        wb_clr[wb_rd_i[k*LNR +: LNR]] = 1'b1;
      end
    end
  end

  // One-hot of the destination; register 0 is never locked.
  always_comb begin
    rd_oh = '0;
    if ((rd_i != '0) && (int'(rd_i) < NR)) begin
      rd_oh[rd_i] = 1'b1;
    end
  end

  assign eff      = locks_q & ~wb_clr;
  assign eff_zero = ~|eff;
  assign hazard   = |(reg_req_i & eff);

  // Next-state, next-lock and issue decision; flush overrides everything.
  always_comb begin
    state_d    = state_q;
    locks_d    = eff;
    pl_ready_o = 1'b0;
    case (state_q)
      RUN: begin
        if (blocking_i) begin
          pl_ready_o = pl_valid_i & eff_zero;
          if (pl_valid_i) begin
            if (eff_zero) begin
              state_d = BLOCKED;
              locks_d = '1;
            end else begin
              state_d = DRAIN;
            end
          end
        end else begin
          pl_ready_o = pl_valid_i & ~hazard;
          if (pl_ready_o) begin
            locks_d = eff | rd_oh;
          end
        end
      end
      DRAIN: begin
        pl_ready_o = pl_valid_i & blocking_i & eff_zero;
        if (!pl_valid_i || !blocking_i) begin
          state_d = RUN;
        end else if (eff_zero) begin
          state_d = BLOCKED;
          locks_d = '1;
        end
      end
      BLOCKED: begin
        locks_d = locks_q;
        if (blk_done_i) begin
          state_d = RUN;
          locks_d = '0;
        end
      end
      default: begin
        state_d = RUN;
        locks_d = '0;
      end
    endcase
    if (flush_i) begin
      state_d    = RUN;
      locks_d    = '0;
      pl_ready_o = 1'b0;
    end
    if (!arst_ni) begin
      pl_ready_o = 1'b0;
    end
  end

  // State and lock registers.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= RUN;
      locks_q <= '0;
    end else begin
      state_q <= state_d;
      locks_q <= locks_d;
    end
  end

  // Saturating count of cycles where a valid instruction could not issue.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      stall_q <= '0;
    end else if (pl_valid_i && !pl_ready_o && (stall_q != {CW{1'b1}})) begin
      stall_q <= stall_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign locks_o     = locks_q;
  assign state_o     = state_q;
  assign stall_cnt_o = stall_q;

endmodule

// File: doc/reg_lock_scoreboard.md
REG_LOCK_SCOREBOARD -- requirements
Module: reg_lock_scoreboard

Interface
REQ-001 Parameter NR, default rv64g_pkg::NUM_REGS, is the number of tracked registers; LNR = $clog2(NR).
REQ-002 Parameter NW, default 2, is the number of writeback (unlock) ports.
REQ-003 Parameter CW, default 16, is the stall counter width.
REQ-004 clk_i  in  1  clock; all state updates on its rising edge.
REQ-005 arst_ni  in  1  asynchronous active-low reset.
REQ-006 flush_i  in  1  pipeline flush; clears all locks.
REQ-007 pl_valid_i  in  1  pipeline instruction valid.
REQ-008 pl_ready_o  out  1  instruction may issue this cycle.
REQ-009 blocking_i  in  1  instruction is blocking (serialising).
REQ-010 rd_i  in  LNR  destination register index.
REQ-011 reg_req_i  in  NR  source register requirement mask.
REQ-012 wb_valid_i  in  NW  per-port writeback valid.
REQ-013 wb_rd_i  in  NW*LNR  per-port writeback register index; port k occupies bits [k*LNR +: LNR].
REQ-014 blk_done_i  in  1  issued blocking instruction has completed.
REQ-015 locks_o  out  NR  current register lock vector.
REQ-016 state_o  out  2  FSM state: 0 RUN, 1 DRAIN, 2 BLOCKED.
REQ-017 stall_cnt_o  out  CW  saturating stall-cycle count.

Function
REQ-018 Definitions: locks_q is the registered lock vector; wb_clr is the OR of one-hot(wb_rd_i[k]) over all k with wb_valid_i[k]=1; eff = locks_q & ~wb_clr.
REQ-019 Writeback bypass: grant decisions use eff, so a register unlocked this cycle is usable this cycle.
REQ-020 fire = pl_valid_i & pl_ready_o.
REQ-021 RUN, non-blocking instruction: pl_ready_o = pl_valid_i & ~|(reg_req_i & eff).
REQ-022 RUN, fire of a non-blocking instruction with rd_i != 0: next locks_q = eff | onehot(rd_i).
REQ-023 When rd_i = 0, no lock is set; bit 0 of locks_o is always 0 outside BLOCKED.
REQ-024 Set and clear of the same register in the same cycle: the set wins (new producer).
REQ-025 Without fire, next locks_q = eff.
REQ-026 RUN, pl_valid_i=1, blocking_i=1, eff=0: pl_ready_o=1; fire moves the FSM to BLOCKED.
REQ-027 RUN, pl_valid_i=1, blocking_i=1, eff!=0: pl_ready_o=0 and the FSM moves to DRAIN.
REQ-028 DRAIN: pl_ready_o = pl_valid_i & blocking_i & (eff==0); writebacks continue to clear locks.
REQ-029 DRAIN, fire: go to BLOCKED.
REQ-030 DRAIN, pl_valid_i=0 or blocking_i=0: return to RUN with no issue that cycle.
REQ-031 BLOCKED: locks_o = all ones, pl_ready_o=0, writebacks ignored.
REQ-032 BLOCKED, blk_done_i=1: go to RUN with locks_q=0 the next cycle; blk_done_i is ignored in other states.
REQ-033 flush_i has highest priority: next cycle locks_q=0 and state=RUN; pl_ready_o=0 during the flush cycle.
REQ-034 stall_cnt_o increments by 1 each cycle that pl_valid_i & ~pl_ready_o, saturating at 2^CW-1; it is not cleared by flush.
REQ-035 Writeback to an unlocked register, or with index >= NR, has no effect.
REQ-036 pl_ready_o is combinational from the inputs and registered state; locks_o and state_o come directly from registers.

Reset
REQ-037 While arst_ni=0: locks_q=0, state=RUN, stall_cnt_o=0, pl_ready_o=0, locks_o=0.
REQ-038 Reset asserted mid-DRAIN or mid-BLOCKED returns to RUN immediately and discards any pending blocking instruction.

Verification
REQ-039 NR=64: issue rd=5, reg_req=0 -> next cycle locks_o=0x20; then reg_req=0x20 -> pl_ready_o=0 and stall_cnt_o increments.
REQ-040 locks_o=0x20, wb_valid=01 with wb_rd=5, reg_req=0x20 same cycle -> pl_ready_o=1 (bypass); if rd_i=5 fires, locks_o stays 0x20 (set wins).
REQ-041 locks_o=0x60, blocking instruction -> DRAIN; wb port0 rd 5, then wb port1 rd 6 -> fire in the cycle eff=0 -> BLOCKED, locks_o=all ones; blk_done_i -> RUN, locks_o=0.
REQ-042 rd_i=0 fire -> locks_o unchanged; flush_i while in BLOCKED -> next cycle state_o=0, locks_o=0.
REQ-043 CW=4 with a permanent stall for 20 cycles -> stall_cnt_o=15.
REQ-044 Random soak for 1e6 cycles with a reference model compare of pl_ready_o, locks_o and state_o each cycle -> zero mismatches; arst_ni pulsed mid-run -> all outputs match their reset values.
